// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks up to two resolved control-flow instructions against their
// fetch-time predictions, emits a registered redirect and queues BTB/BHT updates for the predictor.
package branch_resolve_pkg;
  typedef enum logic [2:0] {
    ControlFlow_None,
    ControlFlow_Branch,
    ControlFlow_Jump,
    ControlFlow_JumpR,
    ControlFlow_Return
  } controlflow_t;

  typedef struct packed {
    logic         valid;
    logic         taken;
    logic [31:0]  target;
    controlflow_t cf;
    logic [1:0]   counter;
  } branch_predict_t;

  typedef struct packed {
    logic         valid;
    logic [31:0]  pc;
    logic [31:0]  target;
    controlflow_t cf;
    logic         taken;
    logic [1:0]   counter;
  } branch_resolved_t;
endpackage

// Handshake: a lane is taken when in_valid[i] & in_ready & ~flush; upstream holds its
// inputs while in_ready is low. resolved_branch has no backpressure: a valid head is
// consumed by the predictor in the cycle it is shown.
module branch_resolve_unit
  import branch_resolve_pkg::*;
#(
  parameter int          FIFO_DEPTH       = 4,
  parameter logic [31:0] DELAYSLOT_OFFSET = 32'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            in_valid,
  input  logic [1:0][31:0]      in_pc,
  input  controlflow_t [1:0]    in_cf,
  input  logic [1:0]            in_taken,
  input  logic [1:0][31:0]      in_target,
  input  branch_predict_t [1:0] in_pred,
  output logic                  in_ready,
  output branch_resolved_t      resolved_branch,
  output logic                  mispredict,
  output logic [31:0]           redirect_pc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]    count;
  logic [PW-1:0]    rptr, wptr;
  branch_resolved_t mem [FIFO_DEPTH];

  logic [1:0]       acc, is_cf, pt, mis_raw, en;
  logic [31:0]      corr [2];
  logic [1:0]       cnt_next [2];
  branch_resolved_t wr_entry [2];
  logic             mis0, mis1, pop;
  logic [1:0]       nwr;

  // Conservative full check: the same-cycle pop is not credited.
  assign in_ready = (count <= CW'(FIFO_DEPTH - 2));

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      acc[i]     = in_valid[i] & in_ready & ~flush;
      is_cf[i]   = (in_cf[i] != ControlFlow_None);
      pt[i]      = in_pred[i].valid & in_pred[i].taken;
      mis_raw[i] = (pt[i] != in_taken[i]) |
                   (in_taken[i] & (in_pred[i].target != in_target[i]));
      corr[i]    = in_taken[i] ? in_target[i] : in_pc[i] + DELAYSLOT_OFFSET;
      cnt_next[i] = in_pred[i].counter;
      if (in_cf[i] == ControlFlow_Branch) begin
        if (in_taken[i] && in_pred[i].counter != 2'd3)
          cnt_next[i] = in_pred[i].counter + 2'd1;
        else if (!in_taken[i] && in_pred[i].counter != 2'd0)
          cnt_next[i] = in_pred[i].counter - 2'd1;
      end
      wr_entry[i] = '{valid: 1'b1, pc: in_pc[i], target: in_target[i], cf: in_cf[i],
                      taken: in_taken[i], counter: cnt_next[i]};
    end
    en[0] = acc[0] & is_cf[0];
    // A mispredicting lane 0 makes lane 1 wrong-path.
    en[1] = acc[1] & is_cf[1] & ~(en[0] & mis_raw[0]);
  end

  assign mis0 = en[0] & mis_raw[0];
  assign mis1 = en[1] & mis_raw[1];
  assign pop  = (count != '0);
  assign nwr  = {1'b0, en[0]} + {1'b0, en[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rptr        <= '0;
      wptr        <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mis0 | mis1;
      if (mis0)
        redirect_pc <= corr[0];
      else if (mis1)
        redirect_pc <= corr[1];
      wptr  <= wptr + PW'(nwr);
      rptr  <= rptr + PW'(pop);
      count <= count + CW'(nwr) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (en[0])
      mem[wptr] <= wr_entry[0];
    if (en[1])
      mem[en[0] ? wptr + PW'(1) : wptr] <= wr_entry[1];
  end

  assign resolved_branch = pop ? mem[rptr] : '0;
endmodule
